// File: rtl/sram_uart_frame_tx.sv
// Fetches a run of 16-bit SRAM words and streams them to the UART as a
// framed packet: HEADER, LEN, data bytes (high byte first), 8-bit checksum.
module sram_uart_frame_tx #(
  parameter int unsigned ADDR_W = 18,
  parameter logic [7:0]  HEADER = 8'h5A
) (
  input  logic              i_clk_sys,
  input  logic              i_rst_n,
  input  logic              i_req_valid,
  input  logic [ADDR_W-1:0] i_req_addr,
  input  logic [7:0]        i_req_len,
  output logic              o_req_ready,
  output logic              o_sram_rd_en,
  output logic [ADDR_W-1:0] o_sram_addr,
  input  logic [15:0]       i_sram_rd_data,
  output logic [7:0]        o_uart_data,
  output logic              o_uart_valid,
  input  logic              i_uart_ready,
  output logic              o_busy
);

  typedef enum logic [2:0] {
    StIdle, StHdr, StLen, StRd, StCap, StDhi, StDlo, StSum
  } state_e;

  state_e            state_q, state_d;
  logic [ADDR_W-1:0] addr_q, addr_d;
  logic [7:0]        len_q, len_d;
  logic [7:0]        remain_q, remain_d;
  logic [7:0]        sum_q, sum_d;
  logic [7:0]        data_q, data_d;
  logic [7:0]        lo_q, lo_d;
  logic              valid_q, valid_d;
  logic              accept;

  assign accept = valid_q && i_uart_ready;

  always_comb begin
    state_d  = state_q;
    addr_d   = addr_q;
    len_d    = len_q;
    remain_d = remain_q;
    sum_d    = sum_q;
    data_d   = data_q;
    lo_d     = lo_q;
    valid_d  = valid_q;
    unique case (state_q)
      StIdle: begin
        if (i_req_valid) begin
          addr_d   = i_req_addr;
          len_d    = i_req_len;
          remain_d = i_req_len;
          sum_d    = 8'h00;
          valid_d  = 1'b1;
          data_d   = HEADER;
          state_d  = StHdr;
        end
      end
      StHdr: begin
        if (accept) begin
          data_d  = len_q;
          state_d = StLen;
        end
      end
      StLen: begin
        if (accept) begin
          sum_d = sum_q + data_q;
          if (len_q != 8'h00) begin
            valid_d = 1'b0;
            state_d = StRd;
          end else begin
            data_d  = sum_q + data_q;
            state_d = StSum;
          end
        end
      end
      StRd: state_d = StCap;
      StCap: begin
        // High byte goes straight into the output register; only the low byte is buffered.
        lo_d     = i_sram_rd_data[7:0];
        data_d   = i_sram_rd_data[15:8];
        valid_d  = 1'b1;
        addr_d   = addr_q + ADDR_W'(1);
        remain_d = remain_q - 8'h01;
        state_d  = StDhi;
      end
      StDhi: begin
        if (accept) begin
          sum_d   = sum_q + data_q;
          data_d  = lo_q;
          state_d = StDlo;
        end
      end
      StDlo: begin
        if (accept) begin
          sum_d = sum_q + data_q;
          if (remain_q != 8'h00) begin
            valid_d = 1'b0;
            state_d = StRd;
          end else begin
            data_d  = sum_q + data_q;
            state_d = StSum;
          end
        end
      end
      StSum: begin
        if (accept) begin
          valid_d = 1'b0;
          state_d = StIdle;
        end
      end
      default: state_d = StIdle;
    endcase
  end

  always_ff @(posedge i_clk_sys or negedge i_rst_n) begin
    if (!i_rst_n) begin
      state_q  <= StIdle;
      addr_q   <= '0;
      len_q    <= 8'h00;
      remain_q <= 8'h00;
      sum_q    <= 8'h00;
      data_q   <= 8'h00;
      lo_q     <= 8'h00;
      valid_q  <= 1'b0;
    end else begin
      state_q  <= state_d;
      addr_q   <= addr_d;
      len_q    <= len_d;
      remain_q <= remain_d;
      sum_q    <= sum_d;
      data_q   <= data_d;
      lo_q     <= lo_d;
      valid_q  <= valid_d;
    end
  end

  assign o_req_ready  = (state_q == StIdle);
  assign o_busy       = (state_q != StIdle);
  assign o_sram_rd_en = (state_q == StRd);
  assign o_sram_addr  = addr_q;
  assign o_uart_data  = data_q;
  assign o_uart_valid = valid_q;

endmodule

// File: tb/tb_sram_uart_frame_tx.sv
// Randomized bench for sram_uart_frame_tx: frames are predicted from the
// memory contents with plain arithmetic and compared against captured bytes.
module tb_sram_uart_frame_tx;
  localparam int unsigned AW = 18;

  logic          clk = 1'b0;
  logic          rst_n = 1'b1;
  logic          req_valid = 1'b0;
  logic [AW-1:0] req_addr = '0;
  logic [7:0]    req_len = 8'h00;
  logic          req_ready;
  logic          sram_rd_en;
  logic [AW-1:0] sram_addr;
  logic [15:0]   sram_rd_data = 16'h0000;
  logic [7:0]    uart_data;
  logic          uart_valid;
  logic          uart_ready = 1'b1;
  logic          busy;

  logic [15:0]   mem [0:(1<<AW)-1];

  logic [7:0]    got_q[$];
  logic [AW-1:0] rd_q[$];
  int            hold_q[$];
  logic [7:0]    exp_b[$];
  logic [AW-1:0] exp_r[$];
  int            hold_cur = 0;
  int            busy_cycles = 0;
  bit            prev_stall = 1'b0;
  logic [7:0]    prev_data = 8'h00;
  int            rdy_mode = 0;
  int            wait_cnt = 0;
  int            pass_cnt = 0;
  int            total_cnt = 0;

  sram_uart_frame_tx dut (
    .i_clk_sys      (clk),
    .i_rst_n        (rst_n),
    .i_req_valid    (req_valid),
    .i_req_addr     (req_addr),
    .i_req_len      (req_len),
    .o_req_ready    (req_ready),
    .o_sram_rd_en   (sram_rd_en),
    .o_sram_addr    (sram_addr),
    .i_sram_rd_data (sram_rd_data),
    .o_uart_data    (uart_data),
    .o_uart_valid   (uart_valid),
    .i_uart_ready   (uart_ready),
    .o_busy         (busy)
  );

  always #5 clk = ~clk;

  // Synchronous-read SRAM: data valid the cycle after the strobe.
  always @(posedge clk) begin
    if (sram_rd_en) sram_rd_data <= mem[sram_addr];
  end

  // Transmitter model: always ready, 3-cycle stall per byte, or random.
  always @(posedge clk) begin
    #1;
    if (rdy_mode == 0) begin
      uart_ready = 1'b1;
    end else if (rdy_mode == 2) begin
      uart_ready = 1'($urandom_range(0, 1));
    end else if (uart_valid && wait_cnt < 3) begin
      uart_ready = 1'b0;
      wait_cnt++;
    end else begin
      uart_ready = uart_valid;
      wait_cnt = 0;
    end
  end

  // Monitor on the falling edge: records handshakes, reads and holds.
  always @(negedge clk) begin
    if (rst_n) begin
      if (prev_stall) begin
        total_cnt++;
        if (!(uart_valid === 1'b1 && uart_data === prev_data))
          $display("FAIL stall_hold: valid=%b data=%h, required valid=1 data=%h",
                   uart_valid, uart_data, prev_data);
        else pass_cnt++;
      end
      if (uart_valid) begin
        hold_cur++;
        if (uart_ready) begin
          got_q.push_back(uart_data);
          hold_q.push_back(hold_cur);
          hold_cur = 0;
        end
      end
      if (sram_rd_en) rd_q.push_back(sram_addr);
      if (busy) busy_cycles++;
      prev_stall = uart_valid && !uart_ready;
      prev_data  = uart_data;
    end else begin
      prev_stall = 1'b0;
      hold_cur   = 0;
    end
  end

  function automatic void build_model(input logic [AW-1:0] a, input logic [7:0] l);
    logic [7:0]    s;
    logic [AW-1:0] ad;
    logic [15:0]   w;
    exp_b.delete();
    exp_r.delete();
    exp_b.push_back(8'h5A);
    exp_b.push_back(l);
    s = l;
    for (int i = 0; i < int'(l); i++) begin
      ad = a + AW'(i);
      w  = mem[ad];
      exp_r.push_back(ad);
      exp_b.push_back(w[15:8]);
      exp_b.push_back(w[7:0]);
      s = 8'(s + w[15:8] + w[7:0]);
    end
    exp_b.push_back(s);
  endfunction

  task automatic clear_mon();
    got_q.delete();
    rd_q.delete();
    hold_q.delete();
    hold_cur    = 0;
    busy_cycles = 0;
  endtask

  // Issue a one-cycle request; returns at the accept edge + 1.
  task automatic send_req(input logic [AW-1:0] a, input logic [7:0] l);
    req_addr  = a;
    req_len   = l;
    req_valid = 1'b1;
    @(posedge clk); #1;
    req_valid = 1'b0;
  endtask

  task automatic wait_idle(output bit ok);
    ok = 1'b0;
    for (int i = 0; i < 4000; i++) begin
      if (!busy) begin
        ok = 1'b1;
        break;
      end
      @(posedge clk); #1;
    end
  endtask

  task automatic test_reset();
    #1 rst_n = 1'b0;
    repeat (3) @(posedge clk);
    #1;
    total_cnt++;
    if (uart_valid !== 1'b0) $display("FAIL rst_valid: got %b required 0", uart_valid);
    else pass_cnt++;
    total_cnt++;
    if (uart_data !== 8'h00) $display("FAIL rst_data: got %h required 00", uart_data);
    else pass_cnt++;
    total_cnt++;
    if (sram_rd_en !== 1'b0) $display("FAIL rst_rd_en: got %b required 0", sram_rd_en);
    else pass_cnt++;
    total_cnt++;
    if (sram_addr !== '0) $display("FAIL rst_addr: got %h required 0", sram_addr);
    else pass_cnt++;
    total_cnt++;
    if (busy !== 1'b0) $display("FAIL rst_busy: got %b required 0", busy);
    else pass_cnt++;
    total_cnt++;
    if (req_ready !== 1'b1) $display("FAIL rst_ready: got %b required 1", req_ready);
    else pass_cnt++;
    rst_n = 1'b1;
    @(posedge clk); #1;
  endtask

  task automatic test_len2();
    bit ok, bad;
    rdy_mode = 0;
    mem[18'h00010] = 16'h1234;
    mem[18'h00011] = 16'hABCD;
    clear_mon();
    send_req(18'h00010, 8'd2);
    total_cnt++;
    if (!(uart_valid === 1'b1 && uart_data === 8'h5A))
      $display("FAIL len2_first: valid=%b data=%h, required valid=1 data=5a",
               uart_valid, uart_data);
    else pass_cnt++;
    wait_idle(ok);
    total_cnt++;
    if (!ok) $display("FAIL len2_timeout: busy stuck high, required idle");
    else pass_cnt++;
    exp_b = '{8'h5A, 8'h02, 8'h12, 8'h34, 8'hAB, 8'hCD, 8'hC0};
    exp_r = '{18'h00010, 18'h00011};
    total_cnt++;
    bad = (got_q.size() != exp_b.size());
    for (int i = 0; i < got_q.size() && !bad; i++) if (got_q[i] !== exp_b[i]) bad = 1'b1;
    if (bad) $display("FAIL len2_bytes: got %p required %p", got_q, exp_b);
    else pass_cnt++;
    total_cnt++;
    bad = (rd_q.size() != exp_r.size());
    for (int i = 0; i < rd_q.size() && !bad; i++) if (rd_q[i] !== exp_r[i]) bad = 1'b1;
    if (bad) $display("FAIL len2_reads: got %p required %p", rd_q, exp_r);
    else pass_cnt++;
    total_cnt++;
    if (busy_cycles != 11) $display("FAIL len2_cycles: got %0d required 11", busy_cycles);
    else pass_cnt++;
  endtask

  task automatic test_len0();
    bit ok, bad;
    clear_mon();
    send_req(AW'($urandom), 8'd0);
    wait_idle(ok);
    total_cnt++;
    if (!ok) $display("FAIL len0_timeout: busy stuck high, required idle");
    else pass_cnt++;
    exp_b = '{8'h5A, 8'h00, 8'h00};
    total_cnt++;
    bad = (got_q.size() != exp_b.size());
    for (int i = 0; i < got_q.size() && !bad; i++) if (got_q[i] !== exp_b[i]) bad = 1'b1;
    if (bad) $display("FAIL len0_bytes: got %p required %p", got_q, exp_b);
    else pass_cnt++;
    total_cnt++;
    if (rd_q.size() != 0) $display("FAIL len0_reads: got %0d reads required 0", rd_q.size());
    else pass_cnt++;
    total_cnt++;
    if (busy_cycles != 3) $display("FAIL len0_cycles: got %0d required 3", busy_cycles);
    else pass_cnt++;
  endtask

  task automatic test_backpressure();
    bit ok, bad;
    logic [AW-1:0] a;
    a = AW'($urandom);
    mem[a] = 16'h00FF;
    rdy_mode = 1;
    clear_mon();
    send_req(a, 8'd1);
    wait_idle(ok);
    total_cnt++;
    if (!ok) $display("FAIL bp_timeout: busy stuck high, required idle");
    else pass_cnt++;
    exp_b = '{8'h5A, 8'h01, 8'h00, 8'hFF, 8'h00};
    total_cnt++;
    bad = (got_q.size() != exp_b.size());
    for (int i = 0; i < got_q.size() && !bad; i++) if (got_q[i] !== exp_b[i]) bad = 1'b1;
    if (bad) $display("FAIL bp_bytes: got %p required %p", got_q, exp_b);
    else pass_cnt++;
    total_cnt++;
    bad = (hold_q.size() != 5);
    for (int i = 0; i < hold_q.size() && !bad; i++) if (hold_q[i] != 4) bad = 1'b1;
    if (bad) $display("FAIL bp_hold: got %p required five holds of 4 cycles", hold_q);
    else pass_cnt++;
    rdy_mode = 0;
  endtask

  task automatic test_wrap();
    bit ok, bad;
    build_model(18'h3FFFF, 8'd2);
    clear_mon();
    send_req(18'h3FFFF, 8'd2);
    wait_idle(ok);
    total_cnt++;
    if (!ok) $display("FAIL wrap_timeout: busy stuck high, required idle");
    else pass_cnt++;
    total_cnt++;
    bad = (got_q.size() != exp_b.size());
    for (int i = 0; i < got_q.size() && !bad; i++) if (got_q[i] !== exp_b[i]) bad = 1'b1;
    if (bad) $display("FAIL wrap_bytes: got %p required %p", got_q, exp_b);
    else pass_cnt++;
    exp_r = '{18'h3FFFF, 18'h00000};
    total_cnt++;
    bad = (rd_q.size() != exp_r.size());
    for (int i = 0; i < rd_q.size() && !bad; i++) if (rd_q[i] !== exp_r[i]) bad = 1'b1;
    if (bad) $display("FAIL wrap_reads: got %p required %p", rd_q, exp_r);
    else pass_cnt++;
  endtask

  task automatic test_busy_req();
    bit ok, bad;
    logic [AW-1:0] a;
    a = AW'($urandom);
    build_model(a, 8'd3);
    clear_mon();
    send_req(a, 8'd3);
    repeat (4) @(posedge clk);
    #1;
    total_cnt++;
    if (req_ready !== 1'b0) $display("FAIL busy_ready: got %b required 0", req_ready);
    else pass_cnt++;
    send_req(a + AW'(100), 8'd5);
    wait_idle(ok);
    total_cnt++;
    if (!ok) $display("FAIL busyreq_timeout: busy stuck high, required idle");
    else pass_cnt++;
    total_cnt++;
    bad = (got_q.size() != exp_b.size());
    for (int i = 0; i < got_q.size() && !bad; i++) if (got_q[i] !== exp_b[i]) bad = 1'b1;
    if (bad) $display("FAIL busyreq_bytes: got %p required %p", got_q, exp_b);
    else pass_cnt++;
    total_cnt++;
    bad = (rd_q.size() != exp_r.size());
    for (int i = 0; i < rd_q.size() && !bad; i++) if (rd_q[i] !== exp_r[i]) bad = 1'b1;
    if (bad) $display("FAIL busyreq_reads: got %p required %p", rd_q, exp_r);
    else pass_cnt++;
    a = AW'($urandom);
    build_model(a, 8'd2);
    clear_mon();
    send_req(a, 8'd2);
    wait_idle(ok);
    total_cnt++;
    bad = !ok || (got_q.size() != exp_b.size());
    for (int i = 0; i < got_q.size() && !bad; i++) if (got_q[i] !== exp_b[i]) bad = 1'b1;
    if (bad) $display("FAIL busyreq_fresh: got %p required %p", got_q, exp_b);
    else pass_cnt++;
  endtask

  task automatic test_reset_mid();
    bit ok, bad;
    logic [AW-1:0] a;
    a = AW'($urandom);
    build_model(a, 8'd4);
    clear_mon();
    send_req(a, 8'd4);
    repeat (4) @(posedge clk);
    #1;
    total_cnt++;
    if (!(uart_valid === 1'b1 && uart_data === exp_b[2]))
      $display("FAIL mid_dhi: valid=%b data=%h, required valid=1 data=%h",
               uart_valid, uart_data, exp_b[2]);
    else pass_cnt++;
    rst_n = 1'b0;
    #1;
    total_cnt++;
    if (uart_valid !== 1'b0) $display("FAIL mid_valid: got %b required 0", uart_valid);
    else pass_cnt++;
    total_cnt++;
    if (req_ready !== 1'b1) $display("FAIL mid_ready: got %b required 1", req_ready);
    else pass_cnt++;
    total_cnt++;
    if (busy !== 1'b0) $display("FAIL mid_busy: got %b required 0", busy);
    else pass_cnt++;
    @(posedge clk); #1;
    rst_n = 1'b1;
    clear_mon();
    repeat (5) @(posedge clk);
    #1;
    total_cnt++;
    if (got_q.size() != 0 || rd_q.size() != 0)
      $display("FAIL mid_quiet: got %0d bytes %0d reads required 0 and 0",
               got_q.size(), rd_q.size());
    else pass_cnt++;
    a = AW'($urandom);
    build_model(a, 8'd4);
    clear_mon();
    send_req(a, 8'd4);
    wait_idle(ok);
    total_cnt++;
    bad = !ok || (got_q.size() != exp_b.size());
    for (int i = 0; i < got_q.size() && !bad; i++) if (got_q[i] !== exp_b[i]) bad = 1'b1;
    if (bad) $display("FAIL mid_fresh: got %p required %p", got_q, exp_b);
    else pass_cnt++;
    total_cnt++;
    if (busy_cycles != 19) $display("FAIL mid_cycles: got %0d required 19", busy_cycles);
    else pass_cnt++;
  endtask

  task automatic test_random();
    bit ok, bad;
    logic [AW-1:0] a;
    logic [7:0]    l;
    rdy_mode = 2;
    for (int n = 0; n < 8; n++) begin
      a = AW'($urandom);
      l = 8'($urandom_range(0, 6));
      for (int i = 0; i < int'(l); i++) mem[a + AW'(i)] = 16'($urandom);
      build_model(a, l);
      clear_mon();
      send_req(a, l);
      wait_idle(ok);
      total_cnt++;
      bad = !ok || (got_q.size() != exp_b.size());
      for (int i = 0; i < got_q.size() && !bad; i++) if (got_q[i] !== exp_b[i]) bad = 1'b1;
      if (bad) $display("FAIL rand_bytes[%0d]: got %p required %p", n, got_q, exp_b);
      else pass_cnt++;
      total_cnt++;
      bad = (rd_q.size() != exp_r.size());
      for (int i = 0; i < rd_q.size() && !bad; i++) if (rd_q[i] !== exp_r[i]) bad = 1'b1;
      if (bad) $display("FAIL rand_reads[%0d]: got %p required %p", n, rd_q, exp_r);
      else pass_cnt++;
    end
    rdy_mode = 0;
    @(posedge clk); #1;
  endtask

  task automatic test_back_to_back();
    bit ok, bad;
    int idle_seen;
    logic [AW-1:0] a1, a2;
    logic [7:0]    cat_b[$];
    logic [AW-1:0] cat_r[$];
    a1 = AW'($urandom);
    a2 = AW'($urandom);
    build_model(a1, 8'd1);
    cat_b = exp_b;
    cat_r = exp_r;
    build_model(a2, 8'd1);
    foreach (exp_b[i]) cat_b.push_back(exp_b[i]);
    foreach (exp_r[i]) cat_r.push_back(exp_r[i]);
    clear_mon();
    req_addr  = a1;
    req_len   = 8'd1;
    req_valid = 1'b1;
    @(posedge clk); #1;
    req_addr  = a2;
    idle_seen = 0;
    for (int i = 0; i < 100; i++) begin
      if (got_q.size() >= 10) break;
      if (!busy) idle_seen++;
      else if (idle_seen > 0) req_valid = 1'b0;
      @(posedge clk); #1;
    end
    req_valid = 1'b0;
    wait_idle(ok);
    total_cnt++;
    if (!ok || idle_seen != 1)
      $display("FAIL b2b_gap: got %0d idle cycles required 1", idle_seen);
    else pass_cnt++;
    total_cnt++;
    bad = (got_q.size() != cat_b.size());
    for (int i = 0; i < got_q.size() && !bad; i++) if (got_q[i] !== cat_b[i]) bad = 1'b1;
    if (bad) $display("FAIL b2b_bytes: got %p required %p", got_q, cat_b);
    else pass_cnt++;
    total_cnt++;
    bad = (rd_q.size() != cat_r.size());
    for (int i = 0; i < rd_q.size() && !bad; i++) if (rd_q[i] !== cat_r[i]) bad = 1'b1;
    if (bad) $display("FAIL b2b_reads: got %p required %p", rd_q, cat_r);
    else pass_cnt++;
  endtask

  initial begin
    for (int i = 0; i < (1 << AW); i++) mem[i] = 16'($urandom);
    test_reset();
    test_len2();
    test_len0();
    test_backpressure();
    test_wrap();
    test_busy_req();
    test_reset_mid();
    test_random();
    test_back_to_back();
    $display("%0d/%0d checks passed", pass_cnt, total_cnt);
    $finish;
  end

endmodule

// File: doc/sram_uart_frame_tx.md
# sram_uart_frame_tx

Response framer for the photo-frame SRAM path. It accepts a read request (start address and word count), fetches 16-bit words from SRAM over a synchronous read port, and serialises them as a framed byte stream toward the UART transmitter. The frame format is 0x5A header, length, data bytes, checksum. It is the transmit-side counterpart of the command path that consumes 0x5A-headed byte frames from the UART receiver.

## Interface
Parameters:
- ADDR_W, 18, SRAM word-address width
- HEADER, 8'h5A, frame start byte

Ports:
- i_clk_sys  in  1  system clock; all logic on rising edge
- i_rst_n  in  1  asynchronous, active-low reset
- i_req_valid  in  1  read request strobe
- i_req_addr  in  ADDR_W  first SRAM word address
- i_req_len  in  8  number of 16-bit words to send (0 allowed)
- o_req_ready  out  1  high only in IDLE; request taken when i_req_valid && o_req_ready
- o_sram_rd_en  out  1  one-cycle read strobe
- o_sram_addr  out  ADDR_W  read address, valid with o_sram_rd_en
- i_sram_rd_data  in  16  read data, valid exactly 1 cycle after o_sram_rd_en
- o_uart_data  out  8  byte to transmitter
- o_uart_valid  out  1  byte valid
- i_uart_ready  in  1  transmitter accepts byte when o_uart_valid && i_uart_ready
- o_busy  out  1  high in every state except IDLE

## Operation
- Frame: HEADER, LEN (= latched i_req_len), then for each word the high byte followed by the low byte, then SUM.
- SUM is the 8-bit modulo-256 sum of LEN and all data bytes. HEADER is excluded from SUM.
- FSM states:
  - IDLE: o_req_ready=1. On accept, latch addr/len, clear sum, go to HDR.
  - HDR: present HEADER. On accept, go to LEN.
  - LEN: present len. On accept, go to RD if len≠0, else go to SUM.
  - RD: o_sram_rd_en=1 for one cycle, o_sram_addr=current addr. Go to CAP.
  - CAP: register i_sram_rd_data into word buffer, addr+1, remaining−1. Go to DHI.
  - DHI: present word[15:8]. On accept, go to DLO.
  - DLO: present word[7:0]. On accept, go to RD if remaining≠0, else go to SUM.
  - SUM: present sum. On accept, go to IDLE.
- The sum accumulator adds o_uart_data on every accepted byte in LEN/DHI/DLO.
- Address increments modulo 2^ADDR_W; 0x3FFFF wraps to 0x00000 without error.
- Requests presented while not in IDLE are ignored (o_req_ready=0). They are not queued.

## Timing
- Reset values:
  - o_uart_valid=0, o_uart_data=0x00
  - o_sram_rd_en=0, o_sram_addr=0
  - o_busy=0
  - state IDLE, hence o_req_ready=1 even while reset is asserted
- Reset mid-frame: asynchronous return to IDLE. The partial frame is abandoned, with no SUM byte and no further SRAM reads.
- Request accepted at edge N: o_uart_valid=1 with 0x5A from cycle N+1.
- o_uart_valid is registered. While o_uart_valid && !i_uart_ready, o_uart_data is held stable and o_uart_valid stays high.
- With i_uart_ready tied 1, each byte state lasts 1 cycle. Each word costs 4 cycles (RD, CAP, DHI, DLO).
  - A len=L frame occupies 2+4L+1 cycles from first valid to return to IDLE.
  - o_uart_valid is low during RD and CAP.
- o_sram_rd_en is never asserted outside RD. Exactly len reads are issued per frame.
- o_req_ready returns to 1 the cycle after SUM is accepted. A back-to-back request can be accepted that same cycle.

## Test plan
- len=2, addr=0x00010, mem[0x10]=0x1234, mem[0x11]=0xABCD, ready=1
  - accepted bytes in order: 5A 02 12 34 AB CD C0
  - exactly 2 rd_en pulses, at addresses 0x10 and 0x11
  - o_busy falls after C0
- len=0, any addr
  - bytes: 5A 00 00
  - no o_sram_rd_en pulse
- Backpressure: len=1, mem=0x00FF; i_uart_ready low for 3 cycles on every byte
  - each byte is held stable for 4 cycles
  - bytes: 5A 01 00 FF 00
- Address wrap: addr=0x3FFFF, len=2
  - reads at 0x3FFFF then 0x00000
  - checksum matches model
- Request during busy: second i_req_valid pulse mid-frame is ignored and the frame is unchanged. A new request issued after IDLE produces a fresh frame.
- Reset mid-frame: assert i_rst_n=0 during DHI of len=4
  - o_uart_valid=0 immediately
  - o_req_ready=1
  - next request produces a complete, correct frame
